// File: rtl/mux_scan_sel_pkg.sv
// Shared types and constants for the scanning channel selector.
// The state enum names the three operating states. The mode constants give
// the encoding of the mode input.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    HOLD   = 2'd2
  } scan_state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Freezing the display takes precedence over the mode input, so a hold
  // request always wins. Otherwise the mode input chooses the state.
  function automatic scan_state_t pick_state(input logic hold_req,
                                             input logic mode_req);
    scan_state_t result;
    if (hold_req) begin
      result = HOLD;
    end else if (mode_req == MODE_SCAN) begin
      result = SCAN;
    end else begin
      result = MANUAL;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_scan_sel_dwell_counter.sv
// Dwell timer for scan mode. It counts 0..DWELL-1 while enabled and flags the
// last count with tc, so the owner knows when to advance the channel. It wraps
// back to 0 on its own. clr forces it to 0. With en low it keeps its value,
// so that a paused scan can resume where it stopped.
module dwell_counter #(
  parameter int DWELL = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // A one-cycle dwell still needs a real register bit. It simply sits at 0,
  // and tc stays high.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  assign tc = (count == CNT_LAST);

  // Count register: clear has priority, then count with wrap at the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (tc) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-channel selector with manual, auto-scan and hold modes.
// The current inputs choose this cycle's behaviour, so a hold or mode change
// takes effect on the very edge where it is seen. The registered state only
// remembers where we came from.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 50_000_000,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          ch,
  output logic                      y_valid,
  output logic                      ch_stb,
  output logic                      sel_err
);

  // One extra bit lets the channel count be compared against sel, even when
  // CHANNELS is an exact power of two.
  localparam logic [SEL_W:0]   CH_COUNT = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);

  scan_state_t      state;
  scan_state_t      state_next;
  logic [SEL_W-1:0] ch_next;
  logic [WIDTH-1:0] y_next;
  logic             sel_ok;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;

  assign sel_ok = ({1'b0, sel} < CH_COUNT);

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // State register: remembers the state applied on the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MANUAL;
    end else begin
      state <= state_next;
    end
  end

  // Next state, next channel and dwell-counter control.
  // The counter is zeroed on the way into MANUAL and is never enabled there,
  // so it stays 0 for as long as MANUAL lasts. As a result, a later entry to
  // SCAN from MANUAL starts a fresh dwell, while HOLD leaves the count alone
  // so that it resumes.
  always_comb begin
    state_next = pick_state(hold, mode);
    ch_next    = ch;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_next)
      MANUAL: begin
        cnt_clr = (state != MANUAL);
        if (sel_ok) begin
          ch_next = sel;
        end
      end
      SCAN: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          ch_next = (ch == CH_LAST) ? '0 : ch + 1'b1;
        end
      end
      HOLD: begin
        ch_next = ch;
      end
      default: begin
        ch_next = ch;
      end
    endcase
  end

  // Output mux: picks the word for the channel that will be shown after this edge.
  always_comb begin
    y_next = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_next == SEL_W'(k)) begin
        y_next = din[k*WIDTH +: WIDTH];
      end
    end
  end

  // Output registers. In HOLD, y and ch keep their values. The strobe fires
  // only when the channel really changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      ch      <= '0;
      y_valid <= 1'b0;
      ch_stb  <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      ch      <= ch_next;
      ch_stb  <= (ch_next != ch);
      sel_err <= (state_next == MANUAL) && !sel_ok;
      if (state_next != HOLD) begin
        y       <= y_next;
        y_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel. Instance a is the 4-channel, 3-bit part
// with a 3-cycle dwell. Instance b is a 5-channel, 4-bit part with a 1-cycle
// dwell, used for out-of-range selects and advance-every-cycle scanning.
// Observed outputs are packed as {ch, y, y_valid, ch_stb, sel_err}.
module tb_mux_scan_sel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_mode, a_hold;
  logic [11:0] a_din;
  logic [1:0]  a_sel, a_ch;
  logic [2:0]  a_y;
  logic        a_y_valid, a_ch_stb, a_sel_err;

  logic        b_rst_n, b_mode, b_hold;
  logic [19:0] b_din;
  logic [2:0]  b_sel, b_ch;
  logic [3:0]  b_y;
  logic        b_y_valid, b_ch_stb, b_sel_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] a_obs, a_exp;
  logic [9:0] b_obs, b_exp;
  assign a_obs = {a_ch, a_y, a_y_valid, a_ch_stb, a_sel_err};
  assign b_obs = {b_ch, b_y, b_y_valid, b_ch_stb, b_sel_err};

  mux_scan_sel #(.WIDTH(3), .CHANNELS(4), .DWELL(3)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .din(a_din), .sel(a_sel), .mode(a_mode),
    .hold(a_hold), .y(a_y), .ch(a_ch), .y_valid(a_y_valid),
    .ch_stb(a_ch_stb), .sel_err(a_sel_err)
  );

  mux_scan_sel #(.WIDTH(4), .CHANNELS(5), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .din(b_din), .sel(b_sel), .mode(b_mode),
    .hold(b_hold), .y(b_y), .ch(b_ch), .y_valid(b_y_valid),
    .ch_stb(b_ch_stb), .sel_err(b_sel_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; a_din = {3'd7, 3'd5, 3'd2, 3'd1}; a_sel = 2'd2;
    a_mode = 1'b0;  a_hold = 1'b0;
    b_rst_n = 1'b0; b_din = {4'd12, 4'd9, 4'd5, 4'd3, 4'd1}; b_sel = 3'd1;
    b_mode = 1'b0;  b_hold = 1'b0;
    step(); step();
    a_exp = 8'b0;
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL reset_a got %b expected %b", a_obs, a_exp); end
    b_exp = 10'b0;
    checks++;
    if (b_obs !== b_exp) begin errors++; $display("[TB] FAIL reset_b got %b expected %b", b_obs, b_exp); end
    a_rst_n = 1'b1;
    step();
    a_exp = {2'd2, 3'd5, 1'b1, 1'b1, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL release_sel2 got %b expected %b", a_obs, a_exp); end
    step();
    a_exp = {2'd2, 3'd5, 1'b1, 1'b0, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL manual_steady got %b expected %b", a_obs, a_exp); end
  endtask

  task automatic test_scan_wrap();
    logic [2:0] ytab [4];
    logic [1:0] ech;
    logic       es;
    ytab = '{3'd1, 3'd2, 3'd5, 3'd7};
    a_mode = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      ech = 2'((2 + i / 3) % 4);
      es  = (i % 3 == 0);
      a_exp = {ech, ytab[ech], 1'b1, es, 1'b0};
      checks++;
      if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL scan_wrap step %0d got %b expected %b", i, a_obs, a_exp); end
    end
  endtask

  task automatic test_hold();
    step();
    a_exp = {2'd2, 3'd5, 1'b1, 1'b0, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL pre_hold got %b expected %b", a_obs, a_exp); end
    a_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_din[8:6] = 3'(i);
      a_sel = 2'(i);
      step();
      a_exp = {2'd2, 3'd5, 1'b1, 1'b0, 1'b0};
      checks++;
      if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL hold_frozen %0d got %b expected %b", i, a_obs, a_exp); end
    end
    a_din[8:6] = 3'd4;
    a_hold = 1'b0;
    step();
    a_exp = {2'd2, 3'd4, 1'b1, 1'b0, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL hold_release_1 got %b expected %b", a_obs, a_exp); end
    step();
    a_exp = {2'd3, 3'd7, 1'b1, 1'b1, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL hold_release_2 got %b expected %b", a_obs, a_exp); end
    a_din[8:6] = 3'd5;
  endtask

  task automatic test_collision();
    step(); step();
    a_exp = {2'd3, 3'd7, 1'b1, 1'b0, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL pre_collision got %b expected %b", a_obs, a_exp); end
    a_hold = 1'b1;
    step();
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL collision_hold_wins got %b expected %b", a_obs, a_exp); end
    a_hold = 1'b0;
    step();
    a_exp = {2'd0, 3'd1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL collision_resume got %b expected %b", a_obs, a_exp); end
    step(); step(); step();
    a_exp = {2'd1, 3'd2, 1'b1, 1'b1, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL scan_to_ch1 got %b expected %b", a_obs, a_exp); end
    a_rst_n = 1'b0;
    #1;
    a_exp = 8'b0;
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL async_reset got %b expected %b", a_obs, a_exp); end
    a_mode = 1'b0; a_sel = 2'd0;
    step();
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL reset_held got %b expected %b", a_obs, a_exp); end
    a_rst_n = 1'b1;
    step();
    a_exp = {2'd0, 3'd1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL reset_recover got %b expected %b", a_obs, a_exp); end
  endtask

  task automatic test_live_tracking();
    a_din[2:0] = 3'd6;
    step();
    a_exp = {2'd0, 3'd6, 1'b1, 1'b0, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL live_din got %b expected %b", a_obs, a_exp); end
  endtask

  task automatic test_mode_sel_same_edge();
    a_sel = 2'd3;
    step();
    a_exp = {2'd3, 3'd7, 1'b1, 1'b1, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL manual_sel3 got %b expected %b", a_obs, a_exp); end
    a_mode = 1'b1; a_sel = 2'd1;
    step();
    a_exp = {2'd3, 3'd7, 1'b1, 1'b0, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL mode_wins_scan got %b expected %b", a_obs, a_exp); end
    a_mode = 1'b0; a_sel = 2'd1;
    step();
    a_exp = {2'd1, 3'd2, 1'b1, 1'b1, 1'b0};
    checks++;
    if (a_obs !== a_exp) begin errors++; $display("[TB] FAIL mode_wins_manual got %b expected %b", a_obs, a_exp); end
  endtask

  task automatic test_out_of_range();
    b_rst_n = 1'b1;
    step();
    b_exp = {3'd1, 4'd3, 1'b1, 1'b1, 1'b0};
    checks++;
    if (b_obs !== b_exp) begin errors++; $display("[TB] FAIL oor_start got %b expected %b", b_obs, b_exp); end
    b_sel = 3'd6;
    step();
    b_exp = {3'd1, 4'd3, 1'b1, 1'b0, 1'b1};
    checks++;
    if (b_obs !== b_exp) begin errors++; $display("[TB] FAIL oor_sel6 got %b expected %b", b_obs, b_exp); end
    b_sel = 3'd5;
    step();
    checks++;
    if (b_obs !== b_exp) begin errors++; $display("[TB] FAIL oor_sel5 got %b expected %b", b_obs, b_exp); end
    b_sel = 3'd4;
    step();
    b_exp = {3'd4, 4'd12, 1'b1, 1'b1, 1'b0};
    checks++;
    if (b_obs !== b_exp) begin errors++; $display("[TB] FAIL oor_sel4 got %b expected %b", b_obs, b_exp); end
    b_sel = 3'd7; b_hold = 1'b1;
    step();
    b_exp = {3'd4, 4'd12, 1'b1, 1'b0, 1'b0};
    checks++;
    if (b_obs !== b_exp) begin errors++; $display("[TB] FAIL oor_hold_masks got %b expected %b", b_obs, b_exp); end
    b_hold = 1'b0;
    step();
    b_exp = {3'd4, 4'd12, 1'b1, 1'b0, 1'b1};
    checks++;
    if (b_obs !== b_exp) begin errors++; $display("[TB] FAIL oor_sel7 got %b expected %b", b_obs, b_exp); end
  endtask

  task automatic test_dwell_one();
    logic [3:0] ytab [5];
    logic [2:0] ech;
    ytab = '{4'd1, 4'd3, 4'd5, 4'd9, 4'd12};
    b_mode = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      ech = 3'((4 + i) % 5);
      b_exp = {ech, ytab[ech], 1'b1, 1'b1, 1'b0};
      checks++;
      if (b_obs !== b_exp) begin errors++; $display("[TB] FAIL dwell_one step %0d got %b expected %b", i, b_obs, b_exp); end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] starting mux_scan_sel bench");
    test_reset();
    test_scan_wrap();
    test_hold();
    test_collision();
    test_live_tracking();
    test_mode_sel_same_edge();
    test_out_of_range();
    test_dwell_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_sel.md
# mux_scan_sel

Parametrised, registered N-channel, W-bit selector for board-level demo designs: it routes one of CHANNELS packed input words to a registered output, either from an external select (manual mode) or by automatically stepping through all channels with a programmable dwell time (scan mode). A hold input freezes the output for inspection. It replaces the fixed 3-bit 4-to-1 selector wherever channel count, width or auto-scan is needed; typical use is switches in, LEDs/7-segment out.

## Interface
- WIDTH, 3, bits per channel word (>=1)
- CHANNELS, 4, number of input channels (>=2; need not be a power of two)
- DWELL, 50_000_000, clock cycles spent on each channel in scan mode (>=1)
- SEL_W, $clog2(CHANNELS), derived; not overridden
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- din  in  CHANNELS*WIDTH  packed inputs; channel k at bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  channel select, used in manual mode
- mode  in  1  0 = manual, 1 = scan
- hold  in  1  1 = freeze output, channel and dwell counter
- y  out  WIDTH  registered selected word
- ch  out  SEL_W  channel currently driving y
- y_valid  out  1  high from the first load after reset onward
- ch_stb  out  1  one-cycle pulse when ch changes
- sel_err  out  1  registered flag: sel >= CHANNELS this cycle in manual mode

## Operation
- States: MANUAL, SCAN, HOLD. Reset state MANUAL.
- Priority per cycle: hold, then mode. hold=1 -> HOLD; else mode=1 -> SCAN; else MANUAL.
- MANUAL: ch <= sel when sel < CHANNELS; otherwise ch keeps its value and sel_err=1. Dwell counter held at 0.
- SCAN: dwell counter counts 0..DWELL-1; when it reaches DWELL-1, it returns to 0 and ch advances by 1, wrapping CHANNELS-1 -> 0. Scan starts from the current ch.
- Entering SCAN from MANUAL clears the counter. Entering SCAN from HOLD resumes the frozen counter value.
- HOLD: y, ch and counter frozen; din and sel ignored; sel_err=0. Releasing hold returns to the state selected by mode on that cycle.
- y <= din[ch_next] every cycle outside HOLD, so y follows din changes on the selected channel.
- ch_stb=1 exactly in the cycle after ch takes a new value; no pulse when ch is unchanged.
- DWELL=1: ch advances every cycle in SCAN.

## Timing
- Reset values: y=0, ch=0, y_valid=0, ch_stb=0, sel_err=0, counter=0.
- Reset assertion clears all state immediately, also mid-scan; no partial update is retained.
- First rising edge after rst_n deasserts: y loaded, y_valid=1.
- Latency: sel or din to y and ch is 1 cycle, with all outputs registered.
- Scan period: each channel is shown for exactly DWELL cycles; a full cycle takes CHANNELS*DWELL cycles.
- Simultaneous hold rise and dwell terminal count: hold wins, and ch does not advance.
- Mode change and sel change in the same cycle: the new mode applies to that edge.

## Structure
- Package mux_scan_pkg: state enum typedef (MANUAL, SCAN, HOLD), mode encoding constants MODE_MANUAL=0 and MODE_SCAN=1.
- Sub-module dwell_counter: parameter DWELL; inputs clr, en; output tc (terminal count). Width is $clog2(DWELL) with a minimum of 1.
- Top contains the FSM, channel register, output mux/register and strobe logic.

## Test plan
- Reset and manual select (WIDTH=3, CHANNELS=4): din={3'd7,3'd5,3'd2,3'd1}, release reset with sel=2 -> next cycle y=5, ch=2, y_valid=1, ch_stb=1.
- Scan wrap (DWELL=3): mode=1 from ch=2 -> ch sequence 2,3,0,1, each held exactly 3 cycles; y follows 5,7,1,2; ch_stb pulses once per change.
- Hold: assert hold mid-dwell (count=1) for 10 cycles while din changes -> y and ch frozen, no ch_stb; release -> ch advances after 2 more cycles.
- Out-of-range (CHANNELS=5, SEL_W=3): ch=1, sel=6 in manual -> sel_err=1, ch stays 1; sel=4 -> sel_err=0, ch=4.
- Collisions: hold and terminal count in the same cycle -> ch unchanged. Assert rst_n low mid-scan -> all outputs 0 immediately.
- Live input tracking: in manual with sel=0, change din channel 0 from 1 to 6 -> y=6 one cycle later, no ch_stb.
